// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Revision 1.0
`default_nettype none

package imem_loader_pkg;

   // Shared with the instruction memory so both sides agree on depth.
   localparam int IMEM_ADDR_W    = 10;
   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// Host byte stream, control/status and memory write port of the boot loader.
// Revision 1.0
`default_nettype none

interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W
);

   logic              start;
   logic [ADDR_W:0]   num_words;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;
   logic              busy;
   logic              done;
   logic              err_overflow;
   logic [31:0]       checksum;
   logic              cpu_hold;

   modport master (
      output start, num_words, in_valid, in_data,
      input  in_ready, mem_we, mem_waddr, mem_wdata,
      input  busy, done, err_overflow, checksum, cpu_hold
   );

   modport slave (
      input  start, num_words, in_valid, in_data,
      output in_ready, mem_we, mem_waddr, mem_wdata,
      output busy, done, err_overflow, checksum, cpu_hold
   );

endinterface

`default_nettype wire

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; one-cycle word_valid.
// Revision 1.0
`default_nettype none

module imem_loader_word_packer
   import imem_loader_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        clear,
   input  wire logic        byte_valid,
   input  wire logic [7:0]  byte_data,
   output logic             word_complete,
   output logic [31:0]      next_word,
   output logic             word_valid,
   output logic [31:0]      word
);

   localparam logic [BYTE_CNT_W-1:0] C_LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

   logic [BYTE_CNT_W-1:0] r_byte_cnt;
   logic [31:0]           r_shift;

   // New bytes enter at the top so the first byte ends up in bits [7:0].
   assign next_word     = {byte_data, r_shift[31:8]};
   assign word_complete = byte_valid && (r_byte_cnt == C_LAST_BYTE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byte_cnt <= '0;
         r_shift    <= '0;
         word_valid <= 1'b0;
         word       <= '0;
      end else begin
         word_valid <= word_complete;
         if (clear) begin
            r_byte_cnt <= '0;
            r_shift    <= '0;
         end else if (byte_valid) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_shift    <= next_word;
         end
         if (word_complete) begin
            word <= next_word;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: byte stream in, word writes out, CPU held meanwhile.
// Revision 1.0
`default_nettype none

module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = IMEM_ADDR_W,
   parameter int BASE_WORD = 0
)(
   input  wire logic     clk,
   input  wire logic     rst,
   imem_loader_if.slave  bus
);

   localparam logic [ADDR_W+1:0] C_MAX_WORDS = (ADDR_W+2)'((1 << ADDR_W) - BASE_WORD);
   localparam logic [ADDR_W-1:0] C_BASE_ADDR = ADDR_W'(BASE_WORD);
   localparam logic [ADDR_W:0]   C_ONE_WORD  = (ADDR_W+1)'(1);

   state_t            r_state;
   state_t            w_state_nxt;

   logic              w_start_acc;
   logic              w_overflow;
   logic              w_empty;
   logic              w_byte_acc;
   logic              w_word_complete;
   logic              w_last_byte;
   logic [31:0]       w_next_word;
   logic              w_word_valid;
   logic [31:0]       w_word;

   logic [ADDR_W:0]   r_num_words;
   logic [ADDR_W:0]   r_word_cnt;
   logic [ADDR_W-1:0] r_waddr;
   logic [31:0]       r_checksum;
   logic              r_err_overflow;

   assign w_start_acc = bus.start && (r_state != ST_LOAD);
   assign w_overflow  = {1'b0, bus.num_words} > C_MAX_WORDS;
   assign w_empty     = (bus.num_words == '0);
   assign w_byte_acc  = bus.in_valid && (r_state == ST_LOAD);
   assign w_last_byte = w_word_complete && ((r_word_cnt + C_ONE_WORD) == r_num_words);

   imem_loader_word_packer u_packer (
      .clk           (clk),
      .rst           (rst),
      .clear         (w_start_acc),
      .byte_valid    (w_byte_acc),
      .byte_data     (bus.in_data),
      .word_complete (w_word_complete),
      .next_word     (w_next_word),
      .word_valid    (w_word_valid),
      .word          (w_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_start_acc) begin
               if (w_empty || w_overflow) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (w_last_byte) begin
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Address and checksum advance on the same edge that completes the word,
   // so they line up with the write strobe in the following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_num_words    <= '0;
         r_word_cnt     <= '0;
         r_waddr        <= '0;
         r_checksum     <= '0;
         r_err_overflow <= 1'b0;
      end else if (w_start_acc) begin
         r_num_words    <= bus.num_words;
         r_word_cnt     <= '0;
         r_checksum     <= '0;
         r_err_overflow <= w_overflow;
      end else if (w_word_complete) begin
         r_word_cnt <= r_word_cnt + C_ONE_WORD;
         r_waddr    <= C_BASE_ADDR + r_word_cnt[ADDR_W-1:0];
         r_checksum <= r_checksum + w_next_word;
      end
   end

   assign bus.in_ready     = (r_state == ST_LOAD);
   assign bus.busy         = (r_state == ST_LOAD);
   assign bus.cpu_hold     = (r_state == ST_LOAD);
   assign bus.done         = (r_state == ST_DONE);
   assign bus.mem_we       = w_word_valid;
   assign bus.mem_waddr    = r_waddr;
   assign bus.mem_wdata    = w_word;
   assign bus.checksum     = r_checksum;
   assign bus.err_overflow = r_err_overflow;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader against a byte-image reference model.
// Revision 1.0
`default_nettype none

module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int ADDR_W = IMEM_ADDR_W;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W), .BASE_WORD(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0]        img[$];
   logic [ADDR_W-1:0] obs_addr[$];
   logic [31:0]       obs_data[$];

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         obs_addr.push_back(bus.mem_waddr);
         obs_data.push_back(bus.mem_wdata);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input int i);
      return 32'(img[4*i]) | (32'(img[4*i+1]) << 8) | (32'(img[4*i+2]) << 16) | (32'(img[4*i+3]) << 24);
   endfunction

   function automatic logic [31:0] model_sum(input int n);
      logic [31:0] s = 0;
      for (int i = 0; i < n; i++) s += model_word(i);
      return s;
   endfunction

   task automatic build_random(input int n);
      img.delete();
      for (int i = 0; i < 4*n; i++) img.push_back(8'($urandom));
   endtask

   task automatic pulse_start(input int n);
      obs_addr.delete();
      obs_data.delete();
      @(negedge clk);
      bus.start     = 1'b1;
      bus.num_words = (ADDR_W+1)'(n);
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   // gap_mode: 0 back-to-back, 1 one idle cycle between bytes, 2 random idle cycles
   task automatic send_bytes(input int first, input int count, input int gap_mode);
      for (int i = first; i < first + count; i++) begin
         if (i > first && gap_mode != 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            repeat ((gap_mode == 1) ? 1 : $urandom_range(0, 2)) @(negedge clk);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = img[i];
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   // Called in the cycle after the final byte: completion flags plus every write.
   task automatic check_load(input string tag, input int n);
      check({tag, ".done"},     64'(bus.done), 64'(1));
      check({tag, ".busy"},     64'(bus.busy), 64'(0));
      check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(0));
      check({tag, ".cpu_hold"}, 64'(bus.cpu_hold), 64'(0));
      check({tag, ".last_we"},  64'(bus.mem_we), 64'(1));
      check({tag, ".checksum"}, 64'(bus.checksum), 64'(model_sum(n)));
      #1;
      check({tag, ".nwrites"},  64'(obs_addr.size()), 64'(n));
      for (int i = 0; i < n && i < obs_addr.size(); i++) begin
         check({tag, ".addr"}, 64'(obs_addr[i]), 64'(i));
         check({tag, ".data"}, 64'(obs_data[i]), 64'(model_word(i)));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".we"},       64'(bus.mem_we), 64'(0));
      check({tag, ".waddr"},    64'(bus.mem_waddr), 64'(0));
      check({tag, ".wdata"},    64'(bus.mem_wdata), 64'(0));
      check({tag, ".busy"},     64'(bus.busy), 64'(0));
      check({tag, ".done"},     64'(bus.done), 64'(0));
      check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(0));
      check({tag, ".ovf"},      64'(bus.err_overflow), 64'(0));
      check({tag, ".checksum"}, 64'(bus.checksum), 64'(0));
      check({tag, ".cpu_hold"}, 64'(bus.cpu_hold), 64'(0));
   endtask

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.num_words = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");

      // Directed two-instruction image, back-to-back
      img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      pulse_start(2);
      check("b2b.busy", 64'(bus.busy), 64'(1));
      send_bytes(0, 8, 0);
      check("b2b.csum_const", 64'(bus.checksum), 64'h001000A6);
      check_load("b2b", 2);

      // Same image with in_valid toggling
      pulse_start(2);
      send_bytes(0, 8, 1);
      check_load("gap", 2);

      // Empty load
      pulse_start(0);
      check("zero.done", 64'(bus.done), 64'(1));
      check("zero.in_ready", 64'(bus.in_ready), 64'(0));
      check("zero.ovf", 64'(bus.err_overflow), 64'(0));
      repeat (4) @(negedge clk);
      check("zero.in_ready_late", 64'(bus.in_ready), 64'(0));
      #1;
      check("zero.nwrites", 64'(obs_addr.size()), 64'(0));

      // Oversized request, then a full-depth load
      pulse_start(DEPTH + 1);
      check("ovf.err", 64'(bus.err_overflow), 64'(1));
      check("ovf.done", 64'(bus.done), 64'(1));
      check("ovf.in_ready", 64'(bus.in_ready), 64'(0));
      repeat (4) @(negedge clk);
      #1;
      check("ovf.nwrites", 64'(obs_addr.size()), 64'(0));
      build_random(DEPTH);
      pulse_start(DEPTH);
      check("full.err_clr", 64'(bus.err_overflow), 64'(0));
      check("full.done_clr", 64'(bus.done), 64'(0));
      send_bytes(0, 4*DEPTH, 0);
      check("full.last_addr", 64'(bus.mem_waddr), 64'(DEPTH - 1));
      check_load("full", DEPTH);

      // Reset after six bytes of a two-word load
      img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      pulse_start(2);
      send_bytes(0, 6, 0);
      rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      #1;
      check("midrst.nwrites", 64'(obs_addr.size()), 64'(1));
      if (obs_addr.size() > 0) begin
         check("midrst.addr0", 64'(obs_addr[0]), 64'(0));
         check("midrst.data0", 64'(obs_data[0]), 64'h00000013);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("midrst.no_2nd", 64'(obs_addr.size()), 64'(1));
      build_random(3);
      pulse_start(3);
      send_bytes(0, 12, 0);
      check_load("postrst", 3);

      // start pulsed mid-load must be ignored
      img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      pulse_start(2);
      send_bytes(0, 2, 0);
      bus.start     = 1'b1;
      bus.num_words = (ADDR_W+1)'(5);
      @(negedge clk);
      bus.start     = 1'b0;
      check("ignore.busy", 64'(bus.busy), 64'(1));
      send_bytes(2, 6, 0);
      check_load("ignore", 2);

      // Randomized loads with random gaps
      for (int t = 0; t < 5; t++) begin
         int n;
         n = $urandom_range(1, 7);
         build_random(n);
         pulse_start(n);
         send_bytes(0, 4*n, 2);
         check_load("rand", n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory. The core's fetch path only ever reads that memory; this block fills it.
- Accepts a byte stream from a host link (UART RX or testbench) over a valid/ready handshake.
- Assembles the bytes little-endian into 32-bit words and drives the memory's word-addressed write port.
- Holds the CPU in reset until the programmed image is complete.

Parameters:
- ADDR_W, 10, word-address width (memory depth 2^ADDR_W words = 1024).
- BASE_WORD, 0, first word index written; the PC byte address is 4*BASE_WORD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load of num_words words.
- num_words  input  ADDR_W+1  number of words to load; sampled when start is accepted.
- in_valid  input  1  byte present on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  block accepts a byte this cycle; transfer occurs when in_valid && in_ready.
- mem_we  output  1  one-cycle write strobe to the instruction memory.
- mem_waddr  output  ADDR_W  word index (equal to PC[ADDR_W+1:2]).
- mem_wdata  output  32  assembled instruction word.
- busy  output  1  load in progress.
- done  output  1  load finished; level, held until the next accepted start.
- err_overflow  output  1  request exceeded memory depth; sticky until the next start.
- checksum  output  32  sum modulo 2^32 of all words written in the current load.
- cpu_hold  output  1  keeps the core in reset; equals busy.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0; word counter 0; shift register 0.
- States: IDLE, LOAD, DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE.
  - start while in LOAD is ignored.
  - On accept: clear checksum, err_overflow and done; zero both counters.
- Transitions on an accepted start:
  - num_words == 0 -> DONE next cycle; no writes.
  - num_words > 2^ADDR_W - BASE_WORD -> set err_overflow, go to DONE; no writes.
  - Otherwise -> LOAD.
- in_ready = 1 exactly when state == LOAD. No back-pressure beyond that.
- Byte assembly:
  - Byte k of each word (k = 0..3) lands in bits [8k+7:8k].
  - The first byte received is the least significant byte.
- Write timing: the 4th byte of a word is accepted at edge N. Then in cycle N+1:
  - mem_we = 1 for exactly one cycle;
  - mem_wdata = the assembled word;
  - mem_waddr = BASE_WORD + word index;
  - checksum includes that word.
- mem_waddr and mem_wdata hold their last values when mem_we = 0.
- Back-to-back bytes are accepted with no bubbles; a new word can begin in the same cycle as the previous word's write.
- Completion:
  - At the edge accepting the last byte of the last word, state moves to DONE.
  - In the following cycle mem_we, done and checksum are all valid together; busy and in_ready drop to 0.
- busy = (state == LOAD). done = (state == DONE).
- Word index never wraps: the overflow check at start guarantees the final index ≤ 2^ADDR_W - 1.
- in_valid with in_ready = 0: the byte is not consumed and no state changes.
- Reset mid-load: immediate return to IDLE. The partial word is discarded and mem_we deasserts asynchronously. Words already written stay in memory.
- A new start in DONE overwrites from BASE_WORD again.

Decomposition:
- Shared package:
  - state enum constants (IDLE/LOAD/DONE);
  - BYTES_PER_WORD = 4;
  - IMEM_ADDR_W = 10, shared with the instruction memory so the depths match.
- One natural sub-module: word_packer. It holds the byte counter and shift register and outputs word_valid/word.
- The top level holds the FSM, address counter, checksum and error logic.

Test Plan:
- Reset, then start with num_words = 2; send bytes 13,00,00,00, 93,00,10,00 -> writes: addr 0 data 0x00000013, then addr 1 data 0x00100093. done = 1 and checksum = 0x001000A6 in the cycle after the last byte.
- Bytes with gaps (in_valid toggling every other cycle) -> same words and addresses as the back-to-back case; exactly two mem_we pulses.
- start with num_words = 0 -> done = 1 the next cycle; mem_we never asserts; in_ready stays 0.
- start with num_words = 1025 (BASE_WORD = 0) -> err_overflow = 1 and done = 1; no writes. A following start with num_words = 1024 writes addresses 0..1023, and the last address is 1023.
- Assert rst after 6 bytes of a 2-word load -> one write (addr 0) occurred; all outputs 0 immediately; no second write. A fresh load afterwards starts at addr 0.
- Pulse start during LOAD with num_words = 5 -> ignored; the original 2-word load completes unchanged.
